// File: rtl/seg_dynamic_scan.sv
// seg_dynamic_scan: binary-to-BCD conversion, blanking, sign and dp, and
// time-multiplexed sel/seg drive for a 6-digit 7-segment display.
module seg_dynamic_scan #(
   parameter int CNT_MAX = 49_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [19:0] data,
   input  logic [5:0]  point,
   input  logic        sign,
   input  logic        seg_en,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t        state;
   logic [19:0]   bin_sr;
   logic [19:0]   data_sat;
   logic [23:0]   acc;
   logic [23:0]   acc_adj;
   logic [23:0]   bcd_q;
   logic [4:0]    bit_cnt;
   logic [CW-1:0] cnt;
   logic [2:0]    dig_idx;
   logic [2:0]    dig_nxt;
   logic [2:0]    top;
   logic [3:0]    nib;
   logic [7:0]    seg_nxt;
   logic          slot_end;

   function automatic logic [6:0] enc7(input logic [3:0] d);
      case (d)
         4'd0:    enc7 = 7'h40;
         4'd1:    enc7 = 7'h79;
         4'd2:    enc7 = 7'h24;
         4'd3:    enc7 = 7'h30;
         4'd4:    enc7 = 7'h19;
         4'd5:    enc7 = 7'h12;
         4'd6:    enc7 = 7'h02;
         4'd7:    enc7 = 7'h78;
         4'd8:    enc7 = 7'h00;
         4'd9:    enc7 = 7'h10;
         default: enc7 = 7'h7F;
      endcase
   endfunction

   assign data_sat = (data > 20'd999_999) ? 20'd999_999 : data;

   genvar n;
   generate
      for (n = 0; n < 6; n++) begin : g_adj
         assign acc_adj[4*n +: 4] = (acc[4*n +: 4] >= 4'd5) ? acc[4*n +: 4] + 4'd3 : acc[4*n +: 4];
      end
   endgenerate

   // Accumulator only reaches bcd_q in LOAD, so the display never sees a partial result.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         bin_sr  <= '0;
         acc     <= '0;
         bit_cnt <= '0;
         bcd_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               bin_sr  <= data_sat;
               acc     <= '0;
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               {acc, bin_sr} <= {acc_adj[22:0], bin_sr, 1'b0};
               bit_cnt       <= bit_cnt + 5'd1;
               state         <= (bit_cnt == 5'd19) ? LOAD : SHIFT;
            end
            LOAD: begin
               bcd_q <= acc;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      top = 3'd0;
      for (int i = 1; i < 6; i++)
         if (bcd_q[4*i +: 4] != 4'd0 || point[i]) top = 3'(i);
   end

   assign slot_end = (cnt == CW'(CNT_MAX));
   assign dig_nxt  = (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
   assign nib      = bcd_q[{dig_nxt, 2'b00} +: 4];
   assign seg_nxt  = (dig_nxt <= top) ? {~point[dig_nxt], enc7(nib)} :
                     (sign && top < 3'd5 && dig_nxt == top + 3'd1) ? 8'hBF : 8'hFF;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt     <= '0;
         dig_idx <= '0;
         sel     <= 6'h00;
         seg     <= 8'hFF;
      end else begin
         cnt <= slot_end ? '0 : cnt + CW'(1);
         if (slot_end) begin
            dig_idx <= dig_nxt;
            sel     <= seg_en ? 6'b000001 << dig_nxt : 6'h00;
            seg     <= seg_en ? seg_nxt : 8'hFF;
         end
      end
   end

endmodule
